// File: rtl/exec_sequencer_if.sv
// rtl/exec_sequencer_if.sv - decode/execute-side bus of the execute-stage sequencer
interface exec_sequencer_if;
    logic [2:0]  mode;
    logic        rw_in;
    logic [4:0]  rd_in;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] d;
    logic [31:0] npc;
    logic        uart_state;
    logic [31:0] pc;
    logic        start;
    logic [31:0] ew_d;
    logic [31:0] ew_rw;
    logic [31:0] ew_rd;
    logic        halted;
    logic        err;
    logic [31:0] retired;

    modport master (
        output mode, rw_in, rd_in, rs_addr, rt_addr, d, npc, uart_state,
        input  rs_data, rt_data, pc, start, ew_d, ew_rw, ew_rd, halted, err, retired
    );

    modport slave (
        input  mode, rw_in, rd_in, rs_addr, rt_addr, d, npc, uart_state,
        output rs_data, rt_data, pc, start, ew_d, ew_rw, ew_rd, halted, err, retired
    );
endinterface

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - PC/register-file sequencer issuing one instruction at a time to execute
// Optional UART wait timeout abort: define EXEC_SEQ_UART_TIMEOUT_EN.
module exec_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int          NREG         = 32,
    parameter int          UART_TIMEOUT = 1048576
) (
    input  logic            clk,
    input  logic            rst,
    exec_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, COMMIT, HALT} state_t;

    localparam logic [5:0] NREG_W    = 6'(NREG);
    localparam logic [2:0] MODE_EXEC = 3'd2;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] ew_d_q;
    logic [31:0] ew_rw_q;
    logic [31:0] ew_rd_q;
    logic [31:0] retired_q;
    logic        start_q;
    logic        halted_q;
    logic [31:0] regs_q [NREG];

    logic exec_mode;
    logic wr_en;
    logic rs_ok;
    logic rt_ok;

    assign exec_mode = (bus.mode == MODE_EXEC);
    assign wr_en     = bus.rw_in && (bus.rd_in != 5'd0) && ({1'b0, bus.rd_in} < NREG_W);
    assign rs_ok     = (bus.rs_addr != 5'd0) && ({1'b0, bus.rs_addr} < NREG_W);
    assign rt_ok     = (bus.rt_addr != 5'd0) && ({1'b0, bus.rt_addr} < NREG_W);

    // Reads see pre-commit contents; execute forwards the in-flight result itself.
    assign bus.rs_data = rs_ok ? regs_q[bus.rs_addr] : 32'h0;
    assign bus.rt_data = rt_ok ? regs_q[bus.rt_addr] : 32'h0;

    assign bus.pc      = pc_q;
    assign bus.start   = start_q;
    assign bus.ew_d    = ew_d_q;
    assign bus.ew_rw   = ew_rw_q;
    assign bus.ew_rd   = ew_rd_q;
    assign bus.halted  = halted_q;
    assign bus.retired = retired_q;

`ifdef EXEC_SEQ_UART_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(UART_TIMEOUT - 1);
    logic [31:0] wait_cnt_q;
    logic        err_q;
    assign bus.err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^UART_TIMEOUT;
    assign bus.err        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            ew_d_q    <= 32'h0;
            ew_rw_q   <= 32'h0;
            ew_rd_q   <= 32'h0;
            retired_q <= 32'h0;
            start_q   <= 1'b0;
            halted_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= 32'h0;
`ifdef EXEC_SEQ_UART_TIMEOUT_EN
            wait_cnt_q <= 32'h0;
            err_q      <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (exec_mode) begin
                        state_q <= ISSUE;
                        start_q <= 1'b1;
                    end
                end
                ISSUE: state_q <= SETTLE;
                SETTLE: begin
                    if (bus.uart_state) begin
                        state_q <= WAIT;
`ifdef EXEC_SEQ_UART_TIMEOUT_EN
                        wait_cnt_q <= 32'h0;
`endif
                    end else begin
                        state_q <= COMMIT;
                    end
                end
                WAIT: begin
                    if (!bus.uart_state) begin
                        state_q <= COMMIT;
`ifdef EXEC_SEQ_UART_TIMEOUT_EN
                    end else if (wait_cnt_q == TIMEOUT_LAST) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                        err_q    <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
`endif
                    end
                end
                COMMIT: begin
                    ew_d_q    <= bus.d;
                    ew_rw_q   <= {31'b0, bus.rw_in};
                    ew_rd_q   <= {27'b0, bus.rd_in};
                    pc_q      <= bus.npc;
                    retired_q <= retired_q + 32'd1;
                    if (wr_en) regs_q[bus.rd_in] <= bus.d;
                    // A jump-to-self marks the end of the program.
                    if (bus.npc == pc_q) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end else if (exec_mode) begin
                        state_q <= ISSUE;
                        start_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                HALT:    state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - scoreboard bench for exec_sequencer
module tb_exec_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exec_sequencer_if bus ();

    exec_sequencer #(
        .RESET_PC    (32'h0),
        .NREG        (32),
        .UART_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] d;
        logic [31:0] rw;
        logic [31:0] rd;
        logic [31:0] pc;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    logic [31:0] prev_ret = 32'h0;
    logic        prev_start = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (bus.retired != prev_ret && bus.retired != 32'h0) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_retire: got=%h want=none", bus.retired);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("ew_d", bus.ew_d, mon_e.d);
                    chk("ew_rw", bus.ew_rw, mon_e.rw);
                    chk("ew_rd", bus.ew_rd, mon_e.rd);
                    chk("pc", bus.pc, mon_e.pc);
                    chk("retired", bus.retired, mon_e.ret);
                end
            end
            if (bus.start) begin
                chk("start_not_back_to_back", {31'b0, prev_start}, 32'h0);
                chk("start_not_when_halted", {31'b0, bus.halted}, 32'h0);
            end
        end
        prev_ret   = bus.retired;
        prev_start = bus.start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!bus.start && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_start"}, {31'b0, bus.start}, 32'h1);
    endtask

    // Issues one instruction; uart_cycles counts cycles uart_state is held high from ISSUE.
    task automatic run_instr(input logic [31:0] dv, input logic [31:0] npcv, input logic rwv,
                             input logic [4:0] rdv, input int uart_cycles, input int exp_lat,
                             input logic [31:0] exp_ret, input string name);
        int          lat;
        logic [31:0] r0;
        wait_start(name);
        r0         = bus.retired;
        bus.rw_in  = rwv;
        bus.rd_in  = rdv;
        bus.npc    = npcv;
        sb_q.push_back('{dv, {31'b0, rwv}, {27'b0, rdv}, npcv, exp_ret});
        if (uart_cycles > 0) begin
            bus.uart_state = 1'b1;
            bus.d          = 32'hDEAD_BEEF;
            repeat (uart_cycles) tick();
            bus.uart_state = 1'b0;
        end
        bus.d = dv;
        lat   = uart_cycles;
        while (bus.retired == r0 && lat < 2000) begin
            tick();
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        int n;
        int starts;
        rst            = 1'b1;
        bus.mode       = 3'd0;
        bus.rw_in      = 1'b0;
        bus.rd_in      = 5'd0;
        bus.rs_addr    = 5'd3;
        bus.rt_addr    = 5'd0;
        bus.d          = 32'h0;
        bus.npc        = 32'h0;
        bus.uart_state = 1'b0;
        tick();
        tick();
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_start", {31'b0, bus.start}, 32'h0);
        chk("rst_ew_d", bus.ew_d, 32'h0);
        chk("rst_ew_rw", bus.ew_rw, 32'h0);
        chk("rst_ew_rd", bus.ew_rd, 32'h0);
        chk("rst_halted", {31'b0, bus.halted}, 32'h0);
        chk("rst_err", {31'b0, bus.err}, 32'h0);
        chk("rst_retired", bus.retired, 32'h0);
        chk("rst_reg3", bus.rs_data, 32'h0);
        rst      = 1'b0;
        bus.mode = 3'd2;

        run_instr(32'h5, 32'h4, 1'b1, 5'd3, 0, 3, 32'd1, "i1");
        chk("i1_reg3", bus.rs_data, 32'h5);
        chk("i1_next_start", {31'b0, bus.start}, 32'h1);

        run_instr(32'hFFFF, 32'h8, 1'b1, 5'd0, 0, 3, 32'd2, "r0w");
        bus.rs_addr = 5'd0;
        bus.rt_addr = 5'd3;
        #1;
        chk("r0_reads_zero", bus.rs_data, 32'h0);
        chk("reg3_kept", bus.rt_data, 32'h5);

        run_instr(32'h41, 32'hC, 1'b1, 5'd7, 11, 13, 32'd3, "uart");
        bus.rs_addr = 5'd7;
        #1;
        chk("uart_reg7", bus.rs_data, 32'h41);

        wait_start("mdrop");
        bus.rw_in      = 1'b1;
        bus.rd_in      = 5'd9;
        bus.npc        = 32'h10;
        bus.uart_state = 1'b1;
        sb_q.push_back('{32'h99, 32'h1, 32'h9, 32'h10, 32'd4});
        repeat (3) tick();
        bus.mode = 3'd0;
        repeat (2) tick();
        bus.uart_state = 1'b0;
        bus.d          = 32'h99;
        n = 0;
        while (bus.retired != 32'd4 && n < 50) begin
            tick();
            n++;
        end
        chk("mdrop_commit", bus.retired, 32'd4);
        starts = 0;
        repeat (10) begin
            tick();
            if (bus.start) starts++;
        end
        chk("mdrop_idle_no_start", 32'(starts), 32'h0);
        bus.mode = 3'd2;
        tick();
        chk("resume_start", {31'b0, bus.start}, 32'h1);
        chk("resume_pc", bus.pc, 32'h10);

        bus.uart_state = 1'b1;
        bus.rw_in      = 1'b1;
        bus.rd_in      = 5'd4;
`ifdef EXEC_SEQ_UART_TIMEOUT_EN
        n = 0;
        while (!bus.halted && n < 100) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'd18);
        chk("timeout_err", {31'b0, bus.err}, 32'h1);
        chk("timeout_halted", {31'b0, bus.halted}, 32'h1);
`else
        repeat (1000) tick();
        chk("stuck_halted", {31'b0, bus.halted}, 32'h0);
        chk("stuck_err", {31'b0, bus.err}, 32'h0);
        chk("stuck_start", {31'b0, bus.start}, 32'h0);
`endif
        chk("stuck_pc", bus.pc, 32'h10);
        chk("stuck_retired", bus.retired, 32'd4);
        bus.uart_state = 1'b0;
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;

        run_instr(32'h1, 32'h40, 1'b0, 5'd0, 0, 3, 32'd1, "to40");
        run_instr(32'h2, 32'h40, 1'b1, 5'd5, 0, 3, 32'd2, "self");
        chk("halt_flag", {31'b0, bus.halted}, 32'h1);
        bus.rs_addr = 5'd5;
        bus.d       = 32'h77;
        starts      = 0;
        repeat (100) begin
            tick();
            if (bus.start) starts++;
        end
        chk("halt_no_start", 32'(starts), 32'h0);
        chk("halt_reg5_frozen", bus.rs_data, 32'h2);
        chk("halt_retired", bus.retired, 32'd2);
        chk("halt_pc", bus.pc, 32'h40);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pc", bus.pc, 32'h0);
        chk("async_rst_halted", {31'b0, bus.halted}, 32'h0);
        chk("async_rst_reg5", bus.rs_data, 32'h0);
        tick();
        rst = 1'b0;
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
